// File: rtl/memoria_dados_parametrizada.sv
// Byte-addressable data memory with byte/half/word/double accesses, load extension,
// configurable read latency and error flags for misaligned or out-of-range accesses.
module memoria_dados_parametrizada #(
   parameter int LARGURA_DADOS    = 32,
   parameter int PROFUNDIDADE     = 256,
   parameter int LATENCIA_LEITURA = 1
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic [31:0]              Endereco,
   input  logic [LARGURA_DADOS-1:0] DadosEscrita,
   input  logic                     MemWrite,
   input  logic                     MemRead,
   input  logic [1:0]               Tamanho,
   input  logic                     SemSinal,
   output logic                     Pronto,
   output logic [LARGURA_DADOS-1:0] DadosLidos,
   output logic                     LeituraValida,
   output logic                     ErroAlinhamento,
   output logic                     ErroEndereco
);
   localparam int NUM_BYTES = LARGURA_DADOS / 8;
   localparam int OFF_W     = $clog2(NUM_BYTES);
   localparam int IDX_W     = $clog2(PROFUNDIDADE);
   localparam logic [32:0] LIMITE = 33'(PROFUNDIDADE) * 33'(NUM_BYTES);

   typedef enum logic {OCIOSO, ESPERA} estado_t;

   logic [LARGURA_DADOS-1:0] memoria [PROFUNDIDADE];

   estado_t                  estado;
   logic [1:0]               contador;
   logic [LARGURA_DADOS-1:0] dadosPend_p0;

   logic [OFF_W-1:0]         deslocamento;
   logic [IDX_W-1:0]         indice;
   logic [2:0]               mascaraAlinh;
   logic                     desalinhado;
   logic                     foraFaixa;
   logic                     aceita;
   logic                     acessoOk;
   logic                     escrever;
   logic [NUM_BYTES-1:0]     habByte;
   logic [LARGURA_DADOS-1:0] dadosDeslocados;
   logic [LARGURA_DADOS-1:0] cargaEstendida;

   // Right-justify the addressed bytes and extend them to the full data width.
   function automatic logic [LARGURA_DADOS-1:0] estenderCarga(
      input logic [LARGURA_DADOS-1:0] palavra,
      input logic [OFF_W-1:0]         off,
      input logic [1:0]               tam,
      input logic                     semSinal
   );
      logic [LARGURA_DADOS-1:0] alinhado;
      logic signed [7:0]        byteSinal;
      logic signed [15:0]       meiaSinal;
      logic signed [31:0]       palavraSinal;
      logic [LARGURA_DADOS-1:0] resultado;
      alinhado     = palavra >> {off, 3'b000};
      byteSinal    = $signed(alinhado[7:0]);
      meiaSinal    = $signed(alinhado[15:0]);
      palavraSinal = $signed(alinhado[31:0]);
      case (tam)
         2'b00:   resultado = semSinal ? LARGURA_DADOS'(alinhado[7:0])  : LARGURA_DADOS'(byteSinal);
         2'b01:   resultado = semSinal ? LARGURA_DADOS'(alinhado[15:0]) : LARGURA_DADOS'(meiaSinal);
         2'b10:   resultado = semSinal ? LARGURA_DADOS'(alinhado[31:0]) : LARGURA_DADOS'(palavraSinal);
         default: resultado = alinhado;
      endcase
      return resultado;
   endfunction

   assign deslocamento = Endereco[OFF_W-1:0];
   assign indice       = Endereco[OFF_W +: IDX_W];
   assign foraFaixa    = {1'b0, Endereco} >= LIMITE;

   always_comb begin
      mascaraAlinh = 3'd0;
      habByte      = '0;
      case (Tamanho)
         2'b00: begin mascaraAlinh = 3'd0; habByte = NUM_BYTES'(1);     end
         2'b01: begin mascaraAlinh = 3'd1; habByte = NUM_BYTES'(2'h3);  end
         2'b10: begin mascaraAlinh = 3'd3; habByte = NUM_BYTES'(4'hF);  end
         default: begin mascaraAlinh = 3'd7; habByte = NUM_BYTES'(8'hFF); end
      endcase
      habByte = habByte << deslocamento;
   end

   // A doubleword can never fit a 32-bit word, so it is treated as an alignment fault.
   assign desalinhado = ((Endereco[2:0] & mascaraAlinh) != 3'd0) ||
                        ((Tamanho == 2'b11) && (LARGURA_DADOS == 32));

   assign aceita          = Pronto && (MemWrite || MemRead);
   assign acessoOk        = aceita && !desalinhado && !foraFaixa;
   assign escrever        = acessoOk && MemWrite && !Reset;
   assign dadosDeslocados = DadosEscrita << {deslocamento, 3'b000};
   assign cargaEstendida  = estenderCarga(memoria[indice], deslocamento, Tamanho, SemSinal);

   always_ff @(posedge Clock) begin
      if (escrever)
         for (int b = 0; b < NUM_BYTES; b++)
            if (habByte[b]) memoria[indice][b*8 +: 8] <= dadosDeslocados[b*8 +: 8];
   end

   // Read data is captured at acceptance so later stores cannot disturb it.
   always_ff @(posedge Clock) begin
      if (acessoOk && !MemWrite) dadosPend_p0 <= cargaEstendida;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         estado          <= OCIOSO;
         contador        <= 2'd0;
         Pronto          <= 1'b1;
         DadosLidos      <= '0;
         LeituraValida   <= 1'b0;
         ErroAlinhamento <= 1'b0;
         ErroEndereco    <= 1'b0;
      end else begin
         LeituraValida   <= 1'b0;
         ErroAlinhamento <= 1'b0;
         ErroEndereco    <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (aceita) begin
                  if (desalinhado) ErroAlinhamento <= 1'b1;
                  else if (foraFaixa) ErroEndereco <= 1'b1;
                  else if (!MemWrite) begin
                     if (LATENCIA_LEITURA == 1) begin
                        LeituraValida <= 1'b1;
                        DadosLidos    <= cargaEstendida;
                     end else begin
                        estado   <= ESPERA;
                        Pronto   <= 1'b0;
                        contador <= 2'(LATENCIA_LEITURA - 1);
                     end
                  end
               end
            end
            default: begin
               if (contador == 2'd1) begin
                  estado        <= OCIOSO;
                  Pronto        <= 1'b1;
                  LeituraValida <= 1'b1;
                  DadosLidos    <= dadosPend_p0;
               end else begin
                  contador <= contador - 2'd1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_memoria_dados_parametrizada.sv
// Directed bench: 32-bit/L=1, 32-bit/L=3 and 64-bit/L=1 instances of the data memory.
module tb_memoria_dados_parametrizada;
   logic Clock_tb = 1'b0;
   always #5 Clock_tb = ~Clock_tb;

   int checks   = 0;
   int failures = 0;

   logic        aReset, aMemWrite, aMemRead, aSemSinal, aPronto, aLeituraValida, aErroAlinhamento, aErroEndereco;
   logic [31:0] aEndereco, aDadosEscrita, aDadosLidos;
   logic [1:0]  aTamanho;
   logic        bReset, bMemWrite, bMemRead, bSemSinal, bPronto, bLeituraValida, bErroAlinhamento, bErroEndereco;
   logic [31:0] bEndereco, bDadosEscrita, bDadosLidos;
   logic [1:0]  bTamanho;
   logic        cReset, cMemWrite, cMemRead, cSemSinal, cPronto, cLeituraValida, cErroAlinhamento, cErroEndereco;
   logic [31:0] cEndereco;
   logic [63:0] cDadosEscrita, cDadosLidos;
   logic [1:0]  cTamanho;

   memoria_dados_parametrizada #(.LARGURA_DADOS(32), .PROFUNDIDADE(256), .LATENCIA_LEITURA(1)) dutA (
      .Clock(Clock_tb), .Reset(aReset), .Endereco(aEndereco), .DadosEscrita(aDadosEscrita),
      .MemWrite(aMemWrite), .MemRead(aMemRead), .Tamanho(aTamanho), .SemSinal(aSemSinal),
      .Pronto(aPronto), .DadosLidos(aDadosLidos), .LeituraValida(aLeituraValida),
      .ErroAlinhamento(aErroAlinhamento), .ErroEndereco(aErroEndereco));

   memoria_dados_parametrizada #(.LARGURA_DADOS(32), .PROFUNDIDADE(256), .LATENCIA_LEITURA(3)) dutB (
      .Clock(Clock_tb), .Reset(bReset), .Endereco(bEndereco), .DadosEscrita(bDadosEscrita),
      .MemWrite(bMemWrite), .MemRead(bMemRead), .Tamanho(bTamanho), .SemSinal(bSemSinal),
      .Pronto(bPronto), .DadosLidos(bDadosLidos), .LeituraValida(bLeituraValida),
      .ErroAlinhamento(bErroAlinhamento), .ErroEndereco(bErroEndereco));

   memoria_dados_parametrizada #(.LARGURA_DADOS(64), .PROFUNDIDADE(256), .LATENCIA_LEITURA(1)) dutC (
      .Clock(Clock_tb), .Reset(cReset), .Endereco(cEndereco), .DadosEscrita(cDadosEscrita),
      .MemWrite(cMemWrite), .MemRead(cMemRead), .Tamanho(cTamanho), .SemSinal(cSemSinal),
      .Pronto(cPronto), .DadosLidos(cDadosLidos), .LeituraValida(cLeituraValida),
      .ErroAlinhamento(cErroAlinhamento), .ErroEndereco(cErroEndereco));

   typedef struct {
      int          alvo;
      logic        escr;
      logic        leit;
      logic [31:0] endr;
      logic [63:0] dado;
      logic [1:0]  tam;
      logic        sem;
      logic        expVal;
      logic        expErrA;
      logic        expErrE;
      logic [63:0] expDados;
   } vetor_t;

   vetor_t vetores[$];

   function automatic vetor_t v(input int alvo, input logic escr, input logic leit, input logic [31:0] endr,
                                input logic [63:0] dado, input logic [1:0] tam, input logic sem,
                                input logic expVal, input logic expErrA, input logic expErrE,
                                input logic [63:0] expDados);
      vetor_t r;
      r.alvo = alvo; r.escr = escr; r.leit = leit; r.endr = endr; r.dado = dado; r.tam = tam; r.sem = sem;
      r.expVal = expVal; r.expErrA = expErrA; r.expErrE = expErrE; r.expDados = expDados;
      return r;
   endfunction

   task automatic verificar(input string nome, input logic [63:0] obtido, input logic [63:0] esperado);
      checks++;
      if (obtido !== esperado) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nome, obtido, esperado);
      end
   endtask

   task automatic dirigir(input int alvo, input logic escr, input logic leit, input logic [31:0] endr,
                          input logic [63:0] dado, input logic [1:0] tam, input logic sem);
      aMemWrite = 1'b0; aMemRead = 1'b0; aEndereco = '0; aDadosEscrita = '0; aTamanho = 2'b00; aSemSinal = 1'b0;
      bMemWrite = 1'b0; bMemRead = 1'b0; bEndereco = '0; bDadosEscrita = '0; bTamanho = 2'b00; bSemSinal = 1'b0;
      cMemWrite = 1'b0; cMemRead = 1'b0; cEndereco = '0; cDadosEscrita = '0; cTamanho = 2'b00; cSemSinal = 1'b0;
      case (alvo)
         0: begin aMemWrite = escr; aMemRead = leit; aEndereco = endr; aDadosEscrita = dado[31:0]; aTamanho = tam; aSemSinal = sem; end
         1: begin bMemWrite = escr; bMemRead = leit; bEndereco = endr; bDadosEscrita = dado[31:0]; bTamanho = tam; bSemSinal = sem; end
         default: begin cMemWrite = escr; cMemRead = leit; cEndereco = endr; cDadosEscrita = dado; cTamanho = tam; cSemSinal = sem; end
      endcase
   endtask

   task automatic observar(input int alvo, output logic pronto, output logic valida, output logic errA,
                           output logic errE, output logic [63:0] dados);
      case (alvo)
         0: begin pronto = aPronto; valida = aLeituraValida; errA = aErroAlinhamento; errE = aErroEndereco; dados = {32'h0, aDadosLidos}; end
         1: begin pronto = bPronto; valida = bLeituraValida; errA = bErroAlinhamento; errE = bErroEndereco; dados = {32'h0, bDadosLidos}; end
         default: begin pronto = cPronto; valida = cLeituraValida; errA = cErroAlinhamento; errE = cErroEndereco; dados = cDadosLidos; end
      endcase
   endtask

   // Drive at the falling edge, let one rising edge happen, sample at the next falling edge.
   task automatic ciclo(input int alvo, input logic escr, input logic leit, input logic [31:0] endr,
                        input logic [63:0] dado, input logic [1:0] tam, input logic sem,
                        output logic pronto, output logic valida, output logic errA,
                        output logic errE, output logic [63:0] dados);
      dirigir(alvo, escr, leit, endr, dado, tam, sem);
      @(posedge Clock_tb);
      @(negedge Clock_tb);
      observar(alvo, pronto, valida, errA, errE, dados);
   endtask

   logic        p, vl, ea, ee;
   logic [63:0] d;
   logic        algumaValida;

   initial begin
      // 32-bit, latency 1
      vetores.push_back(v(0, 1, 0, 32'd8,    64'h11223344, 2'b10, 0, 0, 0, 0, 64'h0));
      vetores.push_back(v(0, 0, 1, 32'd8,    64'h0,        2'b10, 0, 1, 0, 0, 64'h11223344));
      vetores.push_back(v(0, 1, 0, 32'd9,    64'hFFFFFFAA, 2'b00, 0, 0, 0, 0, 64'h11223344));
      vetores.push_back(v(0, 0, 1, 32'd8,    64'h0,        2'b10, 0, 1, 0, 0, 64'h1122AA44));
      vetores.push_back(v(0, 0, 1, 32'd9,    64'h0,        2'b00, 0, 1, 0, 0, 64'hFFFFFFAA));
      vetores.push_back(v(0, 0, 1, 32'd9,    64'h0,        2'b00, 1, 1, 0, 0, 64'h000000AA));
      vetores.push_back(v(0, 0, 1, 32'd10,   64'h0,        2'b01, 0, 1, 0, 0, 64'h00001122));
      vetores.push_back(v(0, 0, 1, 32'd6,    64'h0,        2'b10, 0, 0, 1, 0, 64'h00001122));
      vetores.push_back(v(0, 1, 0, 32'd6,    64'hDEADBEEF, 2'b10, 0, 0, 1, 0, 64'h00001122));
      vetores.push_back(v(0, 0, 1, 32'd9,    64'h0,        2'b01, 0, 0, 1, 0, 64'h00001122));
      vetores.push_back(v(0, 0, 1, 32'd8,    64'h0,        2'b10, 0, 1, 0, 0, 64'h1122AA44));
      vetores.push_back(v(0, 1, 0, 32'd1024, 64'h12345678, 2'b10, 0, 0, 0, 1, 64'h1122AA44));
      vetores.push_back(v(0, 0, 1, 32'd1021, 64'h0,        2'b10, 0, 0, 1, 0, 64'h1122AA44));
      vetores.push_back(v(0, 0, 1, 32'd1024, 64'h0,        2'b10, 0, 0, 0, 1, 64'h1122AA44));
      vetores.push_back(v(0, 1, 0, 32'd1020, 64'hCAFEF00D, 2'b10, 0, 0, 0, 0, 64'h1122AA44));
      vetores.push_back(v(0, 0, 1, 32'd1020, 64'h0,        2'b10, 0, 1, 0, 0, 64'hCAFEF00D));
      vetores.push_back(v(0, 0, 1, 32'd1020, 64'h0,        2'b00, 0, 1, 0, 0, 64'h0000000D));
      vetores.push_back(v(0, 0, 1, 32'd1023, 64'h0,        2'b00, 0, 1, 0, 0, 64'hFFFFFFCA));
      vetores.push_back(v(0, 0, 1, 32'd1022, 64'h0,        2'b01, 1, 1, 0, 0, 64'h0000CAFE));
      vetores.push_back(v(0, 0, 1, 32'd1022, 64'h0,        2'b01, 0, 1, 0, 0, 64'hFFFFCAFE));
      vetores.push_back(v(0, 0, 1, 32'd0,    64'h0,        2'b11, 0, 0, 1, 0, 64'hFFFFCAFE));
      vetores.push_back(v(0, 1, 1, 32'd12,   64'h55667788, 2'b10, 0, 0, 0, 0, 64'hFFFFCAFE));
      vetores.push_back(v(0, 0, 1, 32'd12,   64'h0,        2'b10, 0, 1, 0, 0, 64'h55667788));
      vetores.push_back(v(0, 1, 0, 32'd14,   64'h12348001, 2'b01, 0, 0, 0, 0, 64'h55667788));
      vetores.push_back(v(0, 0, 1, 32'd12,   64'h0,        2'b10, 0, 1, 0, 0, 64'h80017788));
      vetores.push_back(v(0, 0, 1, 32'd15,   64'h0,        2'b00, 0, 1, 0, 0, 64'hFFFFFF80));
      // 64-bit, latency 1
      vetores.push_back(v(2, 1, 0, 32'd16,   64'h8000000000000001, 2'b11, 0, 0, 0, 0, 64'h0));
      vetores.push_back(v(2, 0, 1, 32'd16,   64'h0, 2'b11, 0, 1, 0, 0, 64'h8000000000000001));
      vetores.push_back(v(2, 0, 1, 32'd20,   64'h0, 2'b10, 0, 1, 0, 0, 64'hFFFFFFFF80000000));
      vetores.push_back(v(2, 0, 1, 32'd20,   64'h0, 2'b10, 1, 1, 0, 0, 64'h0000000080000000));
      vetores.push_back(v(2, 0, 1, 32'd16,   64'h0, 2'b10, 0, 1, 0, 0, 64'h0000000000000001));
      vetores.push_back(v(2, 0, 1, 32'd20,   64'h0, 2'b11, 0, 0, 1, 0, 64'h0000000000000001));
      vetores.push_back(v(2, 1, 0, 32'd2048, 64'h1, 2'b11, 0, 0, 0, 1, 64'h0000000000000001));
      vetores.push_back(v(2, 1, 0, 32'd2044, 64'hAAAAAAAA7FFFFFFF, 2'b10, 0, 0, 0, 0, 64'h0000000000000001));
      vetores.push_back(v(2, 0, 1, 32'd2044, 64'h0, 2'b10, 0, 1, 0, 0, 64'h000000007FFFFFFF));
      vetores.push_back(v(2, 0, 1, 32'd23,   64'h0, 2'b00, 0, 1, 0, 0, 64'hFFFFFFFFFFFFFF80));

      dirigir(0, 0, 0, 32'd0, 64'h0, 2'b00, 0);
      aReset = 1'b1; bReset = 1'b1; cReset = 1'b1;
      repeat (2) @(posedge Clock_tb);
      @(negedge Clock_tb);
      for (int k = 0; k < 3; k++) begin
         observar(k, p, vl, ea, ee, d);
         verificar($sformatf("reset%0d pronto", k), 64'(p), 64'h1);
         verificar($sformatf("reset%0d flags", k), {61'h0, vl, ea, ee}, 64'h0);
         verificar($sformatf("reset%0d dados", k), d, 64'h0);
      end
      aReset = 1'b0; bReset = 1'b0; cReset = 1'b0;

      for (int i = 0; i < vetores.size(); i++) begin
         ciclo(vetores[i].alvo, vetores[i].escr, vetores[i].leit, vetores[i].endr, vetores[i].dado,
               vetores[i].tam, vetores[i].sem, p, vl, ea, ee, d);
         verificar($sformatf("vec%0d pronto", i), 64'(p), 64'h1);
         verificar($sformatf("vec%0d valida", i), 64'(vl), 64'(vetores[i].expVal));
         verificar($sformatf("vec%0d erroAlinh", i), 64'(ea), 64'(vetores[i].expErrA));
         verificar($sformatf("vec%0d erroEnd", i), 64'(ee), 64'(vetores[i].expErrE));
         verificar($sformatf("vec%0d dados", i), d, vetores[i].expDados);
      end

      // Latency 3: store, then load with a store presented during the wait
      ciclo(1, 1, 0, 32'd8, 64'h11223344, 2'b10, 0, p, vl, ea, ee, d);
      verificar("lat store pronto", 64'(p), 64'h1);
      ciclo(1, 0, 1, 32'd8, 64'h0, 2'b10, 0, p, vl, ea, ee, d);
      verificar("lat N pronto", 64'(p), 64'h0);
      verificar("lat N valida", 64'(vl), 64'h0);
      ciclo(1, 1, 0, 32'd8, 64'h99999999, 2'b10, 0, p, vl, ea, ee, d);
      verificar("lat N+1 pronto", 64'(p), 64'h0);
      verificar("lat N+1 flags", {61'h0, vl, ea, ee}, 64'h0);
      ciclo(1, 0, 0, 32'd0, 64'h0, 2'b00, 0, p, vl, ea, ee, d);
      verificar("lat N+2 pronto", 64'(p), 64'h1);
      verificar("lat N+2 valida", 64'(vl), 64'h1);
      verificar("lat N+2 dados", d, 64'h11223344);
      ciclo(1, 0, 0, 32'd0, 64'h0, 2'b00, 0, p, vl, ea, ee, d);
      verificar("lat N+3 valida", 64'(vl), 64'h0);
      verificar("lat N+3 dados held", d, 64'h11223344);

      ciclo(1, 0, 1, 32'd8, 64'h0, 2'b10, 0, p, vl, ea, ee, d);
      verificar("lat reload pronto", 64'(p), 64'h0);
      ciclo(1, 0, 0, 32'd0, 64'h0, 2'b00, 0, p, vl, ea, ee, d);
      ciclo(1, 0, 0, 32'd0, 64'h0, 2'b00, 0, p, vl, ea, ee, d);
      verificar("lat reload valida", 64'(vl), 64'h1);
      verificar("lat ignored store", d, 64'h11223344);

      // Reset during the wait aborts the read
      ciclo(1, 0, 1, 32'd8, 64'h0, 2'b01, 1, p, vl, ea, ee, d);
      verificar("abort N pronto", 64'(p), 64'h0);
      bReset = 1'b1;
      ciclo(1, 0, 0, 32'd0, 64'h0, 2'b00, 0, p, vl, ea, ee, d);
      verificar("abort reset pronto", 64'(p), 64'h1);
      verificar("abort reset valida", 64'(vl), 64'h0);
      verificar("abort reset dados", d, 64'h0);
      bReset = 1'b0;
      algumaValida = 1'b0;
      for (int k = 0; k < 3; k++) begin
         ciclo(1, 0, 0, 32'd0, 64'h0, 2'b00, 0, p, vl, ea, ee, d);
         algumaValida = algumaValida | vl;
      end
      verificar("abort no valida", 64'(algumaValida), 64'h0);
      verificar("abort pronto after", 64'(p), 64'h1);

      ciclo(1, 0, 1, 32'd6, 64'h0, 2'b10, 0, p, vl, ea, ee, d);
      verificar("lat misaligned erro", 64'(ea), 64'h1);
      verificar("lat misaligned pronto", 64'(p), 64'h1);
      verificar("lat misaligned valida", 64'(vl), 64'h0);

      dirigir(0, 0, 0, 32'd0, 64'h0, 2'b00, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/memoria_dados_parametrizada.md
# memoria_dados_parametrizada

Parametrised byte-addressable data memory for the processor's data path, replacing the fixed 32-bit word memory. It supports byte, halfword, word and (for 64-bit builds) doubleword accesses, with sign or zero extension on loads. Reads have a configurable latency and a ready/valid handshake. Misaligned and out-of-range accesses are flagged instead of corrupting memory.

## Interface
Parameters:
- LARGURA_DADOS, 32, data width in bits; legal values 32 or 64
- PROFUNDIDADE, 256, number of LARGURA_DADOS-wide words; power of two
- LATENCIA_LEITURA, 1, cycles from read acceptance to data valid; legal 1..4

Ports:
- Clock  in  1  single clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high
- Endereco  in  32  byte address, little-endian
- DadosEscrita  in  LARGURA_DADOS  store data; the access size is taken from the low bits
- MemWrite  in  1  store request
- MemRead  in  1  load request
- Tamanho  in  2  access size: 00 byte, 01 half, 10 word, 11 doubleword
- SemSinal  in  1  1 = zero-extend the load, 0 = sign-extend
- Pronto  out  1  block accepts a request this cycle
- DadosLidos  out  LARGURA_DADOS  extended load result
- LeituraValida  out  1  one-cycle pulse: DadosLidos carries a new result
- ErroAlinhamento  out  1  one-cycle pulse: rejected access (misaligned or illegal size)
- ErroEndereco  out  1  one-cycle pulse: rejected access (address out of range)

## Operation
- **Acceptance.** A request is accepted on a rising edge where Pronto=1 and MemWrite or MemRead is high.
  - Endereco, Tamanho, SemSinal and the operation are latched at acceptance.
- **Simultaneous requests.** If MemWrite and MemRead are both high, the write is performed and the read is ignored.
- **Alignment.** The address must be a multiple of the access size (1, 2, 4 or 8 bytes).
  - Tamanho=11 with LARGURA_DADOS=32 is illegal.
  - Either violation raises ErroAlinhamento.
- **Range.** Endereco >= PROFUNDIDADE*LARGURA_DADOS/8 raises ErroEndereco.
  - If an access is both misaligned and out of range, only ErroAlinhamento is raised.
- **Rejected accesses.** The memory is not modified, LeituraValida is not pulsed, and DadosLidos is unchanged.
- **Store.** Only the addressed bytes are written, using byte enables; all other bytes are preserved.
- **Load.**
  - The addressed bytes are extracted and right-justified.
  - They are then sign-extended (SemSinal=0) or zero-extended (SemSinal=1) to LARGURA_DADOS.
  - A full-width access ignores SemSinal.
- **State machine.**
  - OCIOSO: Pronto=1.
    - Valid read with LATENCIA_LEITURA=1: stays in OCIOSO and produces the result directly.
    - Valid read with LATENCIA_LEITURA>1: moves to ESPERA and loads the counter with LATENCIA_LEITURA-1.
  - ESPERA: Pronto=0; the counter decrements each cycle.
    - When the counter reaches 1, the next edge returns the block to OCIOSO with LeituraValida=1.
  - Requests presented while Pronto=0 are ignored, with no error.
- **Read data source.** Memory is read at the acceptance edge, so later writes do not affect an in-flight read.
- **Reset.**
  - Clears these outputs to 0: DadosLidos, LeituraValida, ErroAlinhamento, ErroEndereco.
  - Sets Pronto=1 and the state to OCIOSO.
  - Memory contents are not cleared.
  - Reset during ESPERA aborts the read; no LeituraValida is produced.

## Timing
- Store accepted at edge N: memory is updated at edge N. Stores sustain one per cycle, and Pronto never drops for a store.
- Load accepted at edge N: LeituraValida=1 and DadosLidos valid in the cycle after edge N+LATENCIA_LEITURA-1.
  - Pronto=0 from edge N until that same edge.
  - With LATENCIA_LEITURA=1, back-to-back loads sustain one per cycle.
- DadosLidos holds its last valid value after LeituraValida falls.
- Error pulses: high exactly in the cycle after the accepting edge. Pronto stays 1.
- Store at edge N followed by a load of the same address at edge N+1 returns the new data.

## Test plan
- **Reset.** Reset=1 for 2 cycles → Pronto=1, all other outputs 0.
- **Word write and load (L=1).** Write 0x11223344 to address 8 with Tamanho=10, then load the same word → DadosLidos=0x11223344 one cycle after acceptance, LeituraValida high for 1 cycle.
- **Sub-word stores and loads.** Starting from 0x11223344 at address 8:
  - sb 0xAA at address 9 → word becomes 0x1122AA44.
  - lb at address 9, SemSinal=0 → 0xFFFFFFAA.
  - lbu at address 9 → 0x000000AA.
  - lh at address 10 → 0x00001122.
- **Errors.**
  - lw at address 6 → ErroAlinhamento pulse, no LeituraValida, memory unchanged.
  - sw at address 1024 (PROFUNDIDADE=256) → ErroEndereco pulse.
- **Latency (LATENCIA_LEITURA=3).** Load accepted at edge N → Pronto=0 until edge N+2, LeituraValida in the cycle after edge N+2.
  - A request during the wait is ignored.
  - Reset asserted at edge N+1 → no LeituraValida, Pronto=1.
- **64-bit build.** LARGURA_DADOS=64: write doubleword 0x8000000000000001 at address 16 and load it back → same value returned. Then lw at address 20, SemSinal=0 → 0xFFFFFFFF80000000.
